// File: rtl/vector_lane_serializer.sv
// Holds one 8-lane vector and streams it out one lane per accepted beat.
// Optional LANE_MASK_EN adds in_mask so that only the selected lanes are emitted.
module vector_lane_serializer #(
  parameter int N = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [8*N-1:0] i_in_data,
`ifdef LANE_MASK_EN
  input  logic [7:0]     i_in_mask,
`endif
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N-1:0]   o_out_data,
  output logic [2:0]     o_out_lane,
  output logic           o_out_last,
  output logic           o_done
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [7:0][N-1:0] r_vec;
  logic              r_done;
  logic [7:0]        w_mask, w_ld_mask;
  logic [2:0]        w_first, w_next;
  logic              w_busy, w_last, w_acc, w_load;

`ifdef LANE_MASK_EN
  logic [7:0] r_mask;
  assign w_ld_mask = i_in_mask;
  assign w_mask    = r_mask;
`else
  assign w_ld_mask = 8'hFF;
  assign w_mask    = 8'hFF;
`endif

  function automatic logic [2:0] f_first(input logic [7:0] m);
    f_first = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) f_first = 3'(i);
  endfunction

  // Returns c itself when no higher lane is selected, which marks the last beat.
  function automatic logic [2:0] f_next(input logic [7:0] m, input logic [2:0] c);
    f_next = c;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (3'(i) > c)) f_next = 3'(i);
  endfunction

  assign w_busy     = (r_state == BUSY);
  assign w_first    = f_first(w_ld_mask);
  assign w_next     = f_next(w_mask, r_cnt);
  assign w_last     = w_busy && (w_next == r_cnt);
  assign w_acc      = w_busy && i_out_ready;
  assign o_in_ready = !w_busy || (w_last && i_out_ready);
  assign w_load     = i_in_valid && o_in_ready;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_load && (|w_ld_mask)) begin
          w_state_nx = BUSY;
          w_cnt_nx   = w_first;
        end
      end
      BUSY: begin
        if (w_acc) begin
          if (!w_last) begin
            w_cnt_nx = w_next;
          end else if (w_load && (|w_ld_mask)) begin
            w_cnt_nx = w_first;
          end else begin
            w_state_nx = IDLE;
            w_cnt_nx   = 3'd0;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_vec   <= '0;
      r_done  <= 1'b0;
`ifdef LANE_MASK_EN
      r_mask  <= 8'h00;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      // An empty mask completes the vector immediately, so it also earns a done pulse.
      r_done  <= (w_acc && w_last) || (w_load && !(|w_ld_mask));
      if (w_load) begin
        r_vec <= i_in_data;
`ifdef LANE_MASK_EN
        r_mask <= i_in_mask;
`endif
      end
    end
  end

  assign o_out_valid = w_busy;
  assign o_out_lane  = r_cnt;
  assign o_out_data  = w_busy ? r_vec[r_cnt] : '0;
  assign o_out_last  = w_last;
  assign o_done      = r_done;

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Scoreboard bench for vector_lane_serializer; define LANE_MASK_EN to also cover lane masking.
module tb_vector_lane_serializer;
  localparam int N = 32;

  typedef struct packed {
    logic [2:0]   lane;
    logic [N-1:0] data;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [8*N-1:0] in_data = '0;
  logic [7:0]     in_mask = 8'hFF;
  logic           in_ready, out_valid, out_last, done;
  logic [N-1:0]   out_data;
  logic [2:0]     out_lane;

  beat_t sb[$];
  int    total = 0;
  int    bad = 0;
  logic  exp_done = 1'b0;

  logic [8*N-1:0] vec_a, vec_b;

  vector_lane_serializer #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
`ifdef LANE_MASK_EN
    .i_in_mask   (in_mask),
`endif
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_lane  (out_lane),
    .o_out_last  (out_last),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    logic  nd;
    int    h;
    if (rst) begin
      sb.delete();
      exp_done = 1'b0;
    end else begin
      chk("done", 64'(done), 64'(exp_done));
      nd = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(out_lane), 64'hFFFF);
        end else begin
          b = sb.pop_front();
          chk("lane", 64'(out_lane), 64'(b.lane));
          chk("data", 64'(out_data), 64'(b.data));
          chk("last", 64'(out_last), 64'(b.last));
          nd = b.last;
        end
      end
      if (in_valid && in_ready) begin
        h = -1;
        for (int k = 0; k < 8; k++) if (in_mask[k]) h = k;
        for (int k = 0; k < 8; k++) begin
          if (in_mask[k]) begin
            b.lane = 3'(k);
            b.data = in_data[k*N +: N];
            b.last = (k == h);
            sb.push_back(b);
          end
        end
        if (in_mask == 8'h00) nd = 1'b1;
      end
      exp_done = nd;
    end
  end

  task automatic send(input logic [8*N-1:0] d, input logic [7:0] m);
    int n;
    n = 0;
    in_data  = d;
    in_mask  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_lane(input logic [2:0] l);
    int n;
    n = 0;
    while (!(out_valid && out_lane == l) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("wait_lane", 64'(out_lane), 64'(l));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      vec_a[k*N +: N] = 32'h11111111 * k;
      vec_b[k*N +: N] = 32'hA0 + k;
    end

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_lane",  64'(out_lane),  64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // single vector, full throughput
    send(vec_a, 8'hFF);
    chk("lat_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("thru_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done),      64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_ready", 64'(in_ready),  64'd1);
    @(posedge clk);
    #1 chk("done_once", 64'(done), 64'd0);

    // backpressure at lane 2
    send(vec_a, 8'hFF);
    wait_lane(3'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_lane",  64'(out_lane),  64'd2);
      chk("hold_data",  64'(out_data),  64'h22222222);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 chk("resume_lane", 64'(out_lane), 64'd3);
    drain();

    // back-to-back load during lane 7
    send(vec_a, 8'hFF);
    wait_lane(3'd7);
    in_data  = vec_b;
    in_mask  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_lane",  64'(out_lane),  64'd0);
    chk("b2b_data",  64'(out_data),  64'hA0);
    chk("b2b_done",  64'(done),      64'd1);
    drain();

    // reset mid-vector
    send(vec_a, 8'hFF);
    wait_lane(3'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_done",  64'(done),      64'd0);
    chk("mid_rst_lane",  64'(out_lane),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    send(vec_b, 8'hFF);
    chk("post_rst_lane", 64'(out_lane), 64'd0);
    chk("post_rst_data", 64'(out_data), 64'hA0);
    drain();

`ifdef LANE_MASK_EN
    send(vec_a, 8'h29);
    chk("mask_first_lane", 64'(out_lane), 64'd0);
    drain();
    send(vec_b, 8'hA4);
    chk("mask_first_lane2", 64'(out_lane), 64'd2);
    drain();
    send(vec_a, 8'h00);
    chk("mask0_valid", 64'(out_valid), 64'd0);
    chk("mask0_done",  64'(done),      64'd1);
    chk("mask0_ready", 64'(in_ready),  64'd1);
    @(posedge clk);
    #1 chk("mask0_done_once", 64'(done), 64'd0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
